// File: rtl/conv_col_engine_pkg.sv
// Shared types and default sizing for the column convolution engine.
// The optional ReLU output stage is enabled with CONV_COL_ENGINE_RELU_EN.
package conv_col_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int CONV_ROWS   = 8;
    localparam int CONV_DATA_W = 8;
    localparam int CONV_CH_MAX = 64;
    // Worst case: 3 full-scale products per beat, CH_MAX beats, plus sign.
    localparam int CONV_ACC_W  = 2 * CONV_DATA_W + $clog2(3 * CONV_CH_MAX) + 1;

endpackage

// File: rtl/conv_col_engine_mac.sv
// One output lane: 3-term signed multiply-add feeding a wrapping accumulator.
module conv_col_mac
    import conv_col_engine_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int ACC_W  = CONV_ACC_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] a0,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] f0,
    input  logic signed [DATA_W-1:0] f1,
    input  logic signed [DATA_W-1:0] f2,
    output logic signed [ACC_W-1:0]  acc
);

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [2*DATA_W-1:0] p);
        return {{(ACC_W - 2 * DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    logic signed [2*DATA_W-1:0] p0;
    logic signed [2*DATA_W-1:0] p1;
    logic signed [2*DATA_W-1:0] p2;
    logic signed [ACC_W-1:0]    tap_sum;

    assign p0      = a0 * f0;
    assign p1      = a1 * f1;
    assign p2      = a2 * f2;
    assign tap_sum = sext(p0) + sext(p1) + sext(p2);

    // Accumulator: cleared at job start, adds one tap sum per accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + tap_sum;
        end
    end

endmodule

// File: rtl/conv_col_engine.sv
// 3-tap vertical column convolution engine with channel accumulation,
// stride 1/2 lane mapping and valid/ready result handshake.
// Optional feature: define CONV_COL_ENGINE_RELU_EN to add the per-job i_relu
// input, which clamps negative output lanes to zero.
module conv_col_engine
    import conv_col_engine_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int N_ROWS = CONV_ROWS,
    parameter int CH_MAX = CONV_CH_MAX,
    parameter int ACC_W  = CONV_ACC_W
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             en,
    input  logic                             i_start,
    input  logic                             i_stride2,
    input  logic [$clog2(CH_MAX+1)-1:0]      i_ch_num,
`ifdef CONV_COL_ENGINE_RELU_EN
    input  logic                             i_relu,
`endif
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [N_ROWS*DATA_W-1:0]         i_r,
    input  logic [3*DATA_W-1:0]              i_f,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [N_ROWS*ACC_W-1:0]          o_sum,
    output logic                             o_busy
);

    localparam int CNT_W = $clog2(CH_MAX + 1);

    conv_state_t      state;
    logic             stride2_q;
    logic [CNT_W-1:0] ch_num_q;
    logic [CNT_W-1:0] cnt;
    logic             relu_q;
    logic             clr;
    logic             acc_en;

    logic signed [DATA_W-1:0] rp [0:N_ROWS+1];
    logic signed [DATA_W-1:0] f0;
    logic signed [DATA_W-1:0] f1;
    logic signed [DATA_W-1:0] f2;

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? '0 : v;
    endfunction

    assign clr    = en && (state == IDLE) && i_start;
    assign acc_en = en && (state == ACCUM) && i_valid;

    assign f0 = i_f[0*DATA_W +: DATA_W];
    assign f1 = i_f[1*DATA_W +: DATA_W];
    assign f2 = i_f[2*DATA_W +: DATA_W];

`ifndef CONV_COL_ENGINE_RELU_EN
    assign relu_q = 1'b0;
`endif

    // Zero-padded row vector: rp[k+1] holds row k, both ends are padding.
    always_comb begin
        rp[0]        = '0;
        rp[N_ROWS+1] = '0;
        for (int k = 0; k < N_ROWS; k++) begin
            rp[k+1] = i_r[k*DATA_W +: DATA_W];
        end
    end

    // Job control FSM; all handshake/status outputs are registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            stride2_q <= 1'b0;
            ch_num_q  <= '0;
            cnt       <= '0;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
`ifdef CONV_COL_ENGINE_RELU_EN
            relu_q    <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= ACCUM;
                        stride2_q <= i_stride2;
                        // A zero channel count still consumes one beat.
                        ch_num_q  <= (i_ch_num == '0) ? CNT_W'(1) : i_ch_num;
                        cnt       <= '0;
                        o_ready   <= 1'b1;
                        o_busy    <= 1'b1;
`ifdef CONV_COL_ENGINE_RELU_EN
                        relu_q    <= i_relu;
`endif
                    end
                end
                ACCUM: begin
                    if (i_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == ch_num_q - CNT_W'(1)) begin
                            state   <= DONE;
                            o_ready <= 1'b0;
                            o_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar j = 0; j < N_ROWS; j++) begin : g_lane
        logic signed [DATA_W-1:0] a0;
        logic signed [DATA_W-1:0] a1;
        logic signed [DATA_W-1:0] a2;
        logic signed [ACC_W-1:0]  acc;

        if (j < N_ROWS / 2) begin : g_low
            // Low lanes: centre row j (stride 1) or 2j (stride 2).
            always_comb begin
                if (stride2_q) begin
                    a0 = rp[2*j];
                    a1 = rp[2*j+1];
                    a2 = rp[2*j+2];
                end else begin
                    a0 = rp[j];
                    a1 = rp[j+1];
                    a2 = rp[j+2];
                end
            end
        end else begin : g_high
            // High lanes carry no output in stride 2, so feed them zeros.
            always_comb begin
                if (stride2_q) begin
                    a0 = '0;
                    a1 = '0;
                    a2 = '0;
                end else begin
                    a0 = rp[j];
                    a1 = rp[j+1];
                    a2 = rp[j+2];
                end
            end
        end

        conv_col_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (clr),
            .acc_en (acc_en),
            .a0     (a0),
            .a1     (a1),
            .a2     (a2),
            .f0     (f0),
            .f1     (f1),
            .f2     (f2),
            .acc    (acc)
        );

        // Accumulators are registers, so the result is ready right after the last beat.
        assign o_sum[j*ACC_W +: ACC_W] = relu_q ? relu(acc) : acc;
    end

endmodule

// File: tb/tb_conv_col_engine.sv
// Self-checking bench for conv_col_engine using a result scoreboard.
module tb_conv_col_engine;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int CHM = 64;
    localparam int AW = 25;
    localparam int CW = $clog2(CHM + 1);
    localparam int SW = N * AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          i_start;
    logic          i_stride2;
    logic [CW-1:0] i_ch_num;
    logic          i_relu;
    logic          i_valid;
    logic          o_ready;
    logic [N*DW-1:0] i_r;
    logic [3*DW-1:0] i_f;
    logic          o_valid;
    logic          i_ready;
    logic [SW-1:0] o_sum;
    logic          o_busy;

    int errors = 0;
    int checks = 0;

    logic [SW-1:0] sb [$];
    longint        exp_lane [N];
    bit            cur_s2;
    bit            cur_relu;

    always #5 clk = ~clk;

    conv_col_engine #(
        .DATA_W (DW),
        .N_ROWS (N),
        .CH_MAX (CHM),
        .ACC_W  (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .i_start   (i_start),
        .i_stride2 (i_stride2),
        .i_ch_num  (i_ch_num),
`ifdef CONV_COL_ENGINE_RELU_EN
        .i_relu    (i_relu),
`endif
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_r       (i_r),
        .i_f       (i_f),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_busy    (o_busy)
    );

    // ---------------- reference model ----------------
    function automatic longint row_at(input logic [N*DW-1:0] r, input int idx);
        logic signed [DW-1:0] v;
        if (idx < 0 || idx >= N) return 0;
        v = r[idx*DW +: DW];
        return longint'(v);
    endfunction

    function automatic longint tap(input logic [3*DW-1:0] f, input int k);
        logic signed [DW-1:0] v;
        v = f[k*DW +: DW];
        return longint'(v);
    endfunction

    task automatic model_beat(input logic [N*DW-1:0] r, input logic [3*DW-1:0] f);
        int c;
        for (int j = 0; j < N; j++) begin
            if (!(cur_s2 && j >= N / 2)) begin
                c = cur_s2 ? 2 * j : j;
                exp_lane[j] += tap(f, 0) * row_at(r, c - 1) + tap(f, 1) * row_at(r, c)
                             + tap(f, 2) * row_at(r, c + 1);
            end
        end
    endtask

    task automatic model_push();
        logic [SW-1:0] v;
        longint x;
        v = '0;
        for (int j = 0; j < N; j++) begin
            x = exp_lane[j];
            if (cur_relu && x < 0) x = 0;
            v[j*AW +: AW] = x[AW-1:0];
        end
        sb.push_back(v);
    endtask

    function automatic logic [N*DW-1:0] seq_rows();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(k + 1);
        return r;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_job(input bit s2, input int ch, input bit relu);
        i_start   = 1'b1;
        i_stride2 = s2;
        i_ch_num  = CW'(ch);
        i_relu    = relu;
        @(negedge clk);
        i_start   = 1'b0;
        cur_s2    = s2;
`ifdef CONV_COL_ENGINE_RELU_EN
        cur_relu  = relu;
`else
        cur_relu  = 1'b0;
`endif
        for (int j = 0; j < N; j++) exp_lane[j] = 0;
    endtask

    task automatic beat(input logic [N*DW-1:0] r, input logic [3*DW-1:0] f, input int gap);
        i_valid = 1'b1;
        i_r     = r;
        i_f     = f;
        model_beat(r, f);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic collect(output logic [SW-1:0] s, output bit got);
        got = 1'b0;
        s   = '0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid === 1'b1) begin
                got = 1'b1;
                s   = o_sum;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b want 0 0 0", o_ready, o_valid, o_busy);
        end
        checks++;
        if (o_sum !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h want 0", o_sum);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stride2();
        logic [SW-1:0] s, e;
        bit got;
        int hard [N] = '{8, 20, 32, 44, 0, 0, 0, 0};
        start_job(1'b1, 1, 1'b0);
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL s2_accum: busy=%b ready=%b want 1 1", o_busy, o_ready);
        end
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        model_push();
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL s2_latency: valid=%b want 1 one cycle after accept", o_valid);
        end
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL s2_result: got %h want %h (valid seen=%0d)", s, e, got);
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (s[j*AW +: AW] !== AW'(hard[j])) begin
                errors++;
                $display("FAIL s2_lane%0d: got %0d want %0d", j, $signed(s[j*AW +: AW]), hard[j]);
            end
        end
        release_result();
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_sum !== e) begin
            errors++;
            $display("FAIL s2_idle: busy=%b valid=%b sum=%h want 0 0 %h", o_busy, o_valid, o_sum, e);
        end
    endtask

    task automatic test_stride1();
        logic [SW-1:0] s, e;
        bit got;
        int hard [N] = '{8, 14, 20, 26, 32, 38, 44, 23};
        start_job(1'b0, 1, 1'b0);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL s1_result: got %h want %h (valid seen=%0d)", s, e, got);
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (s[j*AW +: AW] !== AW'(hard[j])) begin
                errors++;
                $display("FAIL s1_lane%0d: got %0d want %0d", j, $signed(s[j*AW +: AW]), hard[j]);
            end
        end
        release_result();
    endtask

    task automatic test_multich_gaps();
        logic [SW-1:0] s, e;
        bit got;
        start_job(1'b1, 3, 1'b0);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 2);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 3);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mc_two_beats: valid=%b ready=%b want 0 1", o_valid, o_ready);
        end
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        model_push();
        // extra valid beats while DONE must not be accumulated
        i_valid = 1'b1;
        repeat (2) @(negedge clk);
        i_valid = 1'b0;
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL mc_result: got %h want %h (valid seen=%0d)", s, e, got);
        end
        checks++;
        if (s[3*AW +: AW] !== AW'(132) || s[0 +: AW] !== AW'(24)) begin
            errors++;
            $display("FAIL mc_lanes: lane0=%0d lane3=%0d want 24 132", s[0 +: AW], s[3*AW +: AW]);
        end
        release_result();
    endtask

    task automatic test_extreme();
        logic [SW-1:0] s, e;
        logic [N*DW-1:0] r;
        bit got;
        int want;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = 8'h80;
        start_job(1'b0, 64, 1'b0);
        for (int b = 0; b < 64; b++) beat(r, {8'h80, 8'h80, 8'h80}, 0);
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL ext_result: got %h want %h (valid seen=%0d)", s, e, got);
        end
        for (int j = 0; j < N; j++) begin
            want = (j == 0 || j == N - 1) ? 2097152 : 3145728;
            checks++;
            if (s[j*AW +: AW] !== AW'(want)) begin
                errors++;
                $display("FAIL ext_lane%0d: got %0d want %0d", j, $signed(s[j*AW +: AW]), want);
            end
        end
        release_result();
    endtask

    task automatic test_backpressure_en();
        logic [SW-1:0] s, e;
        logic [N*DW-1:0] r2;
        bit got;
        for (int k = 0; k < N; k++) r2[k*DW +: DW] = 8'd50;
        start_job(1'b0, 2, 1'b0);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        en      = 1'b0;
        i_valid = 1'b1;
        i_r     = r2;
        repeat (3) @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_hold: ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
        i_valid = 1'b0;
        en      = 1'b1;
        @(negedge clk);
        beat(seq_rows(), {-8'sd2, 8'sd5, 8'sd1}, 0);
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL en_result: got %h want %h (valid seen=%0d)", s, e, got);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                i_start = 1'b1;
                i_stride2 = 1'b1;
                i_ch_num = CW'(1);
            end
            @(negedge clk);
            i_start = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== e) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b ready=%b sum=%h want 1 0 %h", c, o_valid, o_ready, o_sum, e);
            end
        end
        en      = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL en_ready_ignored: valid=%b busy=%b want 1 1", o_valid, o_busy);
        end
        en = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b want 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] s, e;
        logic [N*DW-1:0] rr;
        logic [3*DW-1:0] ff;
        bit got;
        start_job(1'b0, 4, 1'b0);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        beat(seq_rows(), {8'sd3, 8'sd2, 8'sd1}, 0);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (o_sum !== '0 || o_ready !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sum=%h ready=%b valid=%b busy=%b want all 0", o_sum, o_ready, o_valid, o_busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) rr[k*DW +: DW] = DW'($urandom);
        ff = 24'($urandom);
        start_job(1'b1, 0, 1'b0);
        beat(rr, ff, 0);
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL post_reset_ch0: got %h want %h (valid seen=%0d)", s, e, got);
        end
        release_result();
    endtask

    task automatic test_random();
        logic [SW-1:0] s, e;
        logic [N*DW-1:0] rr;
        logic [3*DW-1:0] ff;
        bit got;
        start_job(1'b0, 5, 1'b0);
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < N; k++) rr[k*DW +: DW] = DW'($urandom);
            ff = 24'($urandom);
            beat(rr, ff, $urandom_range(0, 2));
        end
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e) begin
            errors++;
            $display("FAIL random_s1: got %h want %h (valid seen=%0d)", s, e, got);
        end
        release_result();
    endtask

`ifdef CONV_COL_ENGINE_RELU_EN
    task automatic test_relu();
        logic [SW-1:0] s, e;
        bit got;
        start_job(1'b0, 1, 1'b1);
        beat(seq_rows(), {8'hFF, 8'hFF, 8'hFF}, 0);
        model_push();
        collect(s, got);
        e = sb.pop_front();
        checks++;
        if (!got || s !== e || s !== '0) begin
            errors++;
            $display("FAIL relu_result: got %h want %h", s, e);
        end
        release_result();
    endtask
`endif

    initial begin
        rstn      = 1'b0;
        en        = 1'b1;
        i_start   = 1'b0;
        i_stride2 = 1'b0;
        i_ch_num  = '0;
        i_relu    = 1'b0;
        i_valid   = 1'b0;
        i_r       = '0;
        i_f       = '0;
        i_ready   = 1'b0;
        cur_s2    = 1'b0;
        cur_relu  = 1'b0;
        test_reset();
        test_stride2();
        test_stride1();
        test_multich_gaps();
        test_extreme();
        test_backpressure_en();
        test_reset_mid();
        test_random();
`ifdef CONV_COL_ENGINE_RELU_EN
        test_relu();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
